wakeup_tag_broadcast: RTL and testbench
=======================================

# wakeup_tag_broadcast

Produces the per-lane destination-tag broadcasts that drive the wakeup CAM match ports (tag0_i..tagN_i) in the issue queue. Each issued instruction hands over its destination physical tag and execution latency. The block delays the tag in a per-lane shift pipeline and broadcasts it exactly that many cycles later, so dependents wake just in time. It also supports pipeline flush, load-miss cancel by tag, and a per-lane structural ready.

## Interface
- LANES, `ISSUE_WIDTH: number of issue lanes, which is also the number of broadcast lanes.
- WIDTH, 8: physical tag width. It matches the CAM WIDTH.
- MAX_LAT, 4: maximum execution latency in cycles. Must be ≥1.
- LW, $clog2(MAX_LAT+1): width of each latency field.

- clk  in  1  clock. All state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid_i  in  LANES  per-lane issue strobe.
- issue_tag_i  in  LANES*WIDTH  destination tags. Lane i occupies bits [i*WIDTH +: WIDTH].
- issue_lat_i  in  LANES*LW  per-lane latency, legal range 1..MAX_LAT.
- issue_ready_o  out  LANES  combinational. Lane can accept the issue presented this cycle.
- flush_i  in  1  kills every in-flight and presented entry.
- cancel_valid_i  in  1  cancel strobe (load miss / replay).
- cancel_tag_i  in  WIDTH  tag to cancel.
- tag_o  out  LANES*WIDTH  registered broadcast tags. Reads 0 when the lane is not valid.
- tag_valid_o  out  LANES  registered broadcast-valid flags.
- error_o  out  1  sticky protocol-violation flag.

## Operation
- Per lane, slots 0..MAX_LAT-1 each hold {valid, tag}. Slot 0 is the output register that drives tag_o and tag_valid_o.
- Each edge, slot[d] loads slot[d+1] and slot[MAX_LAT-1] loads empty. An accepted issue with latency L writes slot[L-1].
- Tag 0 is reserved as the null tag and is never allocated by rename. An invalid lane drives tag 0 so that the CAM never matches a live entry.
- issue_ready_o[i] is the inverse of the valid bit of slot[L] for the presented L. When L = MAX_LAT there is no slot[L], so ready is 1.
- Collision (valid issue while not ready): the in-flight entry wins and the new issue is dropped. error_o sets and holds until reset.
- An illegal latency (0 or greater than MAX_LAT) with valid issue drops the issue and sets error_o.
- Cancel: every in-flight slot whose shifted-in tag equals cancel_tag_i is written invalid with tag 0 at the edge.
  - A same-cycle issue carrying cancel_tag_i is also dropped.
  - A cancel with tag 0 has no effect.
- Flush: every slot on every lane becomes invalid/0 at the edge. Same-cycle issues and cancels are ignored.
- Priority, highest first: reset_n, flush_i, cancel, issue.
- Lanes are independent. The same tag on two lanes is legal; the issuer must avoid it, and the block does not check for it.

## Timing
- An issue accepted in cycle T with latency L gives tag_valid_o=1 and tag_o=tag during cycle T+L only, a one-cycle pulse.
- L=1 means the tag is visible in the cycle after issue.
- Throughput: one issue per lane per cycle, provided latencies do not collide.
- While reset_n=0: tag_valid_o=0, tag_o=0, error_o=0, issue_ready_o all 1, and all slots are empty. Asserting reset mid-flight discards all entries immediately and asynchronously.
- Flush or cancel in cycle T takes effect on the outputs from cycle T+1. A broadcast already on tag_o during cycle T is not retracted.
- issue_ready_o depends combinationally on issue_lat_i and the slot state. It does not depend on flush_i or cancel_i.

## Test plan
- Latency sweep: LANES=4, MAX_LAT=4. Issue tag 0x11 with L=1, 2, 3, 4 on lanes 0-3 in cycle 10. Lane i pulses tag_valid_o with tag 0x11 in cycle 11+i. All other cycles read 0/0.
- Collision: on lane 0, issue 0x20 with L=3 in cycle 5, then 0x21 with L=2 in cycle 6. In cycle 6, issue_ready_o[0]=0. Only 0x20 broadcasts (cycle 8), and error_o=1 from cycle 7 until reset.
- Cancel: issue 0x30 with L=4 on lane 1 in cycle 0. Present cancel 0x30 in cycle 2. No broadcast occurs in cycle 4. A concurrent 0x31 on lane 2 with L=3 in cycle 0 still broadcasts in cycle 3.
- Flush with simultaneous issue: fill all slots, then assert flush_i together with a valid issue 0x40 L=1 in cycle 7. tag_valid_o=0 in every lane from cycle 8 onward, and 0x40 never appears.
- Back-to-back throughput: issue on lane 3 every cycle for 20 cycles with L=2 and tags 0x50..0x63. Broadcasts appear two cycles later in order, one per cycle, and error_o stays 0.
- Async reset mid-flight: assert reset_n=0 between edges while entries are pending. Outputs go to 0 immediately, and no broadcast follows the release of reset.

Source files
------------

// File: rtl/wakeup_tag_broadcast.sv
// wakeup_tag_broadcast: per-lane shift pipelines that delay issued destination tags
// by their execution latency, then broadcast them to the wakeup CAM.
module wakeup_tag_broadcast #(
    parameter int LANES   = 4,
    parameter int WIDTH   = 8,
    parameter int MAX_LAT = 4,
    parameter int LW      = $clog2(MAX_LAT + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [LANES-1:0]       issue_valid_i,
    input  logic [LANES*WIDTH-1:0] issue_tag_i,
    input  logic [LANES*LW-1:0]    issue_lat_i,
    output logic [LANES-1:0]       issue_ready_o,
    input  logic                   flush_i,
    input  logic                   cancel_valid_i,
    input  logic [WIDTH-1:0]       cancel_tag_i,
    output logic [LANES*WIDTH-1:0] tag_o,
    output logic [LANES-1:0]       tag_valid_o,
    output logic                   error_o
);
    logic [LANES-1:0][MAX_LAT-1:0]            vld_q, vld_d;
    logic [LANES-1:0][MAX_LAT-1:0][WIDTH-1:0] tag_q, tag_d;
    logic                                     err_q, err_d;
    logic [LW-1:0]                            lat;
    logic                                     legal, hit, acc, kill;

    assign kill = cancel_valid_i && cancel_tag_i != '0;

    always_comb begin
        vld_d         = '0;
        tag_d         = '0;
        issue_ready_o = '1;
        err_d         = err_q;
        lat           = '0;
        legal         = 1'b0;
        hit           = 1'b0;
        acc           = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lat   = issue_lat_i[i*LW +: LW];
            legal = lat != '0 && lat <= LW'(MAX_LAT);
            hit   = 1'b0;
            // slot[L] shifts into slot[L-1] this edge, so it must be empty to accept
            for (int d = 1; d < MAX_LAT; d++)
                if (lat == LW'(d) && vld_q[i][d]) hit = 1'b1;
            issue_ready_o[i] = !hit;
            acc = issue_valid_i[i] && legal && !hit &&
                  !(kill && issue_tag_i[i*WIDTH +: WIDTH] == cancel_tag_i);
            vld_d[i] = vld_q[i] >> 1;
            tag_d[i] = tag_q[i] >> WIDTH;
            for (int d = 0; d < MAX_LAT; d++) begin
                if (kill && tag_d[i][d] == cancel_tag_i) begin
                    vld_d[i][d] = 1'b0;
                    tag_d[i][d] = '0;
                end
                if (acc && lat == LW'(d + 1)) begin
                    vld_d[i][d] = 1'b1;
                    tag_d[i][d] = issue_tag_i[i*WIDTH +: WIDTH];
                end
            end
            if (issue_valid_i[i] && (!legal || hit)) err_d = 1'b1;
        end
        if (flush_i) begin
            vld_d = '0;
            tag_d = '0;
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            tag_q <= '0;
            err_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        tag_o       = '0;
        tag_valid_o = '0;
        for (int i = 0; i < LANES; i++) begin
            tag_o[i*WIDTH +: WIDTH] = tag_q[i][0];
            tag_valid_o[i]          = vld_q[i][0];
        end
    end

    assign error_o = err_q;
endmodule

// File: tb/tb_wakeup_tag_broadcast.sv
// tb_wakeup_tag_broadcast: directed and random checks against a schedule-of-broadcasts
// model indexed by absolute cycle.
module tb_wakeup_tag_broadcast;
    localparam int LANES = 4, WIDTH = 8, MAX_LAT = 4, LW = 3, NC = 3000;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [LANES-1:0]       issue_valid = '0;
    logic [LANES*WIDTH-1:0] issue_tag = '0;
    logic [LANES*LW-1:0]    issue_lat = '0;
    logic [LANES-1:0]       issue_ready;
    logic                   flush = 1'b0;
    logic                   cancel_valid = 1'b0;
    logic [WIDTH-1:0]       cancel_tag = '0;
    logic [LANES*WIDTH-1:0] tag_out;
    logic [LANES-1:0]       tag_valid;
    logic                   error;

    wakeup_tag_broadcast #(.LANES(LANES), .WIDTH(WIDTH), .MAX_LAT(MAX_LAT), .LW(LW)) dut (
        .clk(clk), .reset_n(reset_n), .issue_valid_i(issue_valid), .issue_tag_i(issue_tag),
        .issue_lat_i(issue_lat), .issue_ready_o(issue_ready), .flush_i(flush),
        .cancel_valid_i(cancel_valid), .cancel_tag_i(cancel_tag), .tag_o(tag_out),
        .tag_valid_o(tag_valid), .error_o(error)
    );

    always #5 clk = ~clk;

    // ev/et: a broadcast of tag et is due on lane l in absolute cycle c
    bit         ev [LANES][NC];
    logic [7:0] et [LANES][NC];
    bit         em;
    int         cyc, checks, failures;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", nm, cyc, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int l = 0; l < LANES; l++)
            for (int c = 0; c < NC; c++) begin
                ev[l][c] = 1'b0;
                et[l][c] = '0;
            end
    endtask

    task automatic set_issue(input int l, input int tag, input int lat);
        issue_valid[l]              = 1'b1;
        issue_tag[l*WIDTH +: WIDTH] = WIDTH'(tag);
        issue_lat[l*LW +: LW]       = LW'(lat);
    endtask

    task automatic cycle();
        int  lat, tg;
        bit  kill;
        bit  occ [LANES];
        @(negedge clk);
        for (int l = 0; l < LANES; l++) begin
            lat = int'(issue_lat[l*LW +: LW]);
            chk($sformatf("valid_l%0d", l), 64'(tag_valid[l]), 64'(ev[l][cyc]));
            chk($sformatf("tag_l%0d", l), 64'(tag_out[l*WIDTH +: WIDTH]),
                ev[l][cyc] ? 64'(et[l][cyc]) : 64'd0);
            occ[l] = (lat >= 1 && lat <= MAX_LAT) ? ev[l][cyc+lat] : 1'b0;
            if (lat >= 1 && lat <= MAX_LAT)
                chk($sformatf("ready_l%0d", l), 64'(issue_ready[l]), 64'(!occ[l]));
        end
        chk("error", 64'(error), 64'(em));
        if (flush) begin
            for (int l = 0; l < LANES; l++)
                for (int c = cyc + 1; c <= cyc + MAX_LAT; c++) ev[l][c] = 1'b0;
        end else begin
            kill = cancel_valid && cancel_tag != 0;
            if (kill)
                for (int l = 0; l < LANES; l++)
                    for (int c = cyc + 1; c <= cyc + MAX_LAT; c++)
                        if (ev[l][c] && et[l][c] == cancel_tag) ev[l][c] = 1'b0;
            for (int l = 0; l < LANES; l++) begin
                lat = int'(issue_lat[l*LW +: LW]);
                tg  = int'(issue_tag[l*WIDTH +: WIDTH]);
                if (issue_valid[l]) begin
                    if (lat < 1 || lat > MAX_LAT || occ[l]) em = 1'b1;
                    else if (!(kill && tg == int'(cancel_tag))) begin
                        ev[l][cyc+lat] = 1'b1;
                        et[l][cyc+lat] = 8'(tg);
                    end
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        issue_valid  = '0;
        issue_tag    = '0;
        issue_lat    = '0;
        flush        = 1'b0;
        cancel_valid = 1'b0;
        cancel_tag   = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic hard_reset();
        #2 reset_n = 1'b0;
        issue_lat = {LANES{3'd2}};
        #1;
        chk("rst_valid", 64'(tag_valid), 64'd0);
        chk("rst_tag", 64'(tag_out), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_ready", 64'(issue_ready), 64'hF);
        clear_model();
        em = 1'b0;
        @(posedge clk);
        cyc++;
        #1 reset_n = 1'b1;
        issue_lat = '0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        em = 1'b0;
        clear_model();
        #3;
        chk("init_valid", 64'(tag_valid), 64'd0);
        chk("init_tag", 64'(tag_out), 64'd0);
        chk("init_error", 64'(error), 64'd0);
        chk("init_ready", 64'(issue_ready), 64'hF);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // latency sweep: lane i broadcasts 0x11 i+1 cycles after issue
        idle(10);
        for (int l = 0; l < LANES; l++) set_issue(l, 'h11, l + 1);
        cycle();
        idle(6);

        // cancel one in-flight tag, a sibling on another lane survives
        set_issue(1, 'h30, 4);
        set_issue(2, 'h31, 3);
        cycle();
        cycle();
        cancel_valid = 1'b1;
        cancel_tag   = 8'h30;
        cycle();
        idle(4);

        // back-to-back on lane 3
        for (int k = 0; k < 20; k++) begin
            set_issue(3, 'h50 + k, 2);
            cycle();
        end
        idle(3);
        chk("b2b_error", 64'(error), 64'd0);

        // fill every slot, then flush alongside a new issue
        for (int k = 0; k < MAX_LAT; k++) begin
            for (int l = 0; l < LANES; l++) set_issue(l, 'h60 + 4 * k + l, MAX_LAT);
            cycle();
        end
        flush = 1'b1;
        set_issue(0, 'h40, 1);
        cycle();
        for (int k = 0; k < 5; k++) begin
            chk("flush_valid", 64'(tag_valid), 64'd0);
            cycle();
        end

        // collision: second issue lands on the slot the first occupies
        set_issue(0, 'h20, 3);
        cycle();
        set_issue(0, 'h21, 2);
        cycle();
        chk("coll_error", 64'(error), 64'd1);
        idle(4);
        chk("coll_sticky", 64'(error), 64'd1);

        // asynchronous reset with entries pending
        set_issue(0, 'h77, 4);
        set_issue(1, 'h78, 2);
        cycle();
        hard_reset();
        idle(6);

        // random traffic
        for (int k = 0; k < 1000; k++) begin
            for (int l = 0; l < LANES; l++)
                if ($urandom_range(1, 0) == 1)
                    set_issue(l, $urandom_range(15, 1),
                              ($urandom_range(31, 0) == 0) ? $urandom_range(7, 0) : $urandom_range(MAX_LAT, 1));
            if ($urandom_range(7, 0) == 0) begin
                cancel_valid = 1'b1;
                cancel_tag   = 8'($urandom_range(15, 0));
            end
            if ($urandom_range(49, 0) == 0) flush = 1'b1;
            cycle();
        end
        idle(MAX_LAT + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
